// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage registers: exception codes, reset/handler
// PC+8 values, Tnew width, per-stage payload widths and the stage-control encoding.
package pipe_pkg;

   localparam logic [4:0] EXC_NONE = 5'd0;
   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   localparam int PIPE_TNEW_W = 3;
   localparam int PIPE_PC_W   = 32;

   localparam logic [31:0] PIPE_RESET_PC8 = 32'h0000_3008;
   localparam logic [31:0] PIPE_EXC_PC8   = 32'h0000_4188;

   // Payload widths agreed between the producing and consuming stage of each register.
   localparam int PAYLOAD_W_DE = 64;
   localparam int PAYLOAD_W_EM = 72;
   localparam int PAYLOAD_W_MW = 40;

   typedef enum logic [1:0] {
      CTL_LOAD  = 2'd0,
      CTL_STALL = 2'd1,
      CTL_FLUSH = 2'd2,
      CTL_REQ   = 2'd3
   } stage_ctl_e;

endpackage

// File: rtl/pipe_stage_reg_tnew_sat_dec.sv
// Combinational saturating decrement of a Tnew value: 0 stays 0, otherwise minus one.
module tnew_sat_dec
   import pipe_pkg::*;
#(
   parameter int W = PIPE_TNEW_W
) (
   input  logic [W-1:0] i_val,
   output logic [W-1:0] o_val
);

   // Decrement without wrapping below zero.
   always_comb begin
      o_val = {W{1'b0}};
      if (i_val == {W{1'b0}}) begin
         o_val = {W{1'b0}};
      end else begin
         o_val = i_val - W'(1'b1);
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with exception flush (req), bubble (flush) and hold (stall),
// plus optional Tnew ageing while held and a decremented Tnew view for the next stage.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int              PAYLOAD_W         = PAYLOAD_W_DE,
   parameter int              TNEW_W            = PIPE_TNEW_W,
   parameter int              PC_W              = PIPE_PC_W,
   parameter logic [PC_W-1:0] RESET_PC8         = PC_W'(PIPE_RESET_PC8),
   parameter logic [PC_W-1:0] EXC_PC8           = PC_W'(PIPE_EXC_PC8),
   parameter int              TNEW_AGE_ON_STALL = 0,
   parameter int              TNEW_DEC_OUT      = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req,
   input  logic                 flush,
   input  logic                 stall,
   input  logic                 valid_i,
   input  logic [PAYLOAD_W-1:0] payload_i,
   input  logic [PC_W-1:0]      pc8_i,
   input  logic [4:0]           exc_i,
   input  logic                 bd_i,
   input  logic [TNEW_W-1:0]    tnew_i,
   output logic                 valid_o,
   output logic [PAYLOAD_W-1:0] payload_o,
   output logic [PC_W-1:0]      pc8_o,
   output logic [4:0]           exc_o,
   output logic                 bd_o,
   output logic [TNEW_W-1:0]    tnew_o
);

   logic                 r_valid;
   logic [PAYLOAD_W-1:0] r_payload;
   logic [PC_W-1:0]      r_pc8;
   logic [4:0]           r_exc;
   logic                 r_bd;
   logic [TNEW_W-1:0]    r_tnew;

   logic [TNEW_W-1:0]    w_tnew_dec;
   logic [TNEW_W-1:0]    w_tnew_aged;
   logic [TNEW_W-1:0]    w_tnew_held;
   stage_ctl_e           w_ctl;

   tnew_sat_dec #(.W(TNEW_W)) u_dec_out (
      .i_val (r_tnew),
      .o_val (w_tnew_dec)
   );

   tnew_sat_dec #(.W(TNEW_W)) u_dec_age (
      .i_val (r_tnew),
      .o_val (w_tnew_aged)
   );

   assign w_tnew_held = (TNEW_AGE_ON_STALL != 0) ? w_tnew_aged : r_tnew;

   // Resolve the control inputs into one action, highest priority first.
   always_comb begin
      w_ctl = CTL_LOAD;
      if (req) begin
         w_ctl = CTL_REQ;
      end else if (flush) begin
         w_ctl = CTL_FLUSH;
      end else if (stall) begin
         w_ctl = CTL_STALL;
      end else begin
         w_ctl = CTL_LOAD;
      end
   end

   // Stage register update; a bubble keeps pc8/bd so an interrupt on it reports the right EPC/BD.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid   <= 1'b0;
         r_payload <= {PAYLOAD_W{1'b0}};
         r_pc8     <= RESET_PC8;
         r_exc     <= 5'd0;
         r_bd      <= 1'b0;
         r_tnew    <= {TNEW_W{1'b0}};
      end else begin
         case (w_ctl)
            CTL_REQ: begin
               r_valid   <= 1'b0;
               r_payload <= {PAYLOAD_W{1'b0}};
               r_pc8     <= EXC_PC8;
               r_exc     <= 5'd0;
               r_bd      <= 1'b0;
               r_tnew    <= {TNEW_W{1'b0}};
            end
            CTL_FLUSH: begin
               r_valid   <= 1'b0;
               r_payload <= {PAYLOAD_W{1'b0}};
               r_pc8     <= pc8_i;
               r_exc     <= 5'd0;
               r_bd      <= bd_i;
               r_tnew    <= {TNEW_W{1'b0}};
            end
            CTL_STALL: begin
               r_tnew    <= w_tnew_held;
            end
            CTL_LOAD: begin
               r_valid   <= valid_i;
               r_payload <= payload_i;
               r_pc8     <= pc8_i;
               r_exc     <= exc_i;
               r_bd      <= bd_i;
               r_tnew    <= tnew_i;
            end
            default: begin
               r_valid   <= r_valid;
               r_payload <= r_payload;
               r_pc8     <= r_pc8;
               r_exc     <= r_exc;
               r_bd      <= r_bd;
               r_tnew    <= r_tnew;
            end
         endcase
      end
   end

   assign valid_o   = r_valid;
   assign payload_o = r_payload;
   assign pc8_o     = r_pc8;
   assign exc_o     = r_exc;
   assign bd_o      = r_bd;
   assign tnew_o    = (TNEW_DEC_OUT != 0) ? w_tnew_dec : r_tnew;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Three stage-register variants (age+dec, no-age+dec, age+no-dec) driven with shared stimulus
// and compared against a field-level reference model of the register contents.
module tb_pipe_stage_reg;

   typedef struct packed {
      logic        valid;
      logic [63:0] payload;
      logic [31:0] pc8;
      logic [4:0]  exc;
      logic        bd;
      logic [2:0]  tnew;
   } st_t;

   logic        clk;
   logic        reset;
   logic        req, flush, stall, valid_i, bd_i;
   logic [63:0] payload_i;
   logic [31:0] pc8_i;
   logic [4:0]  exc_i;
   logic [2:0]  tnew_i;

   logic [2:0]        v_o, b_o;
   logic [2:0][63:0]  p_o;
   logic [2:0][31:0]  c_o;
   logic [2:0][4:0]   e_o;
   logic [2:0][2:0]   t_o;

   int tests = 0;
   int fails = 0;

   int  age_m [3] = '{1, 0, 1};
   int  dec_m [3] = '{1, 1, 0};
   st_t m     [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      pipe_stage_reg #(
         .PAYLOAD_W         (64),
         .TNEW_W            (3),
         .PC_W              (32),
         .RESET_PC8         (32'h0000_3008),
         .EXC_PC8           (32'h0000_4188),
         .TNEW_AGE_ON_STALL ((g != 1) ? 1 : 0),
         .TNEW_DEC_OUT      ((g != 2) ? 1 : 0)
      ) u_dut (
         .clk       (clk),
         .reset     (reset),
         .req       (req),
         .flush     (flush),
         .stall     (stall),
         .valid_i   (valid_i),
         .payload_i (payload_i),
         .pc8_i     (pc8_i),
         .exc_i     (exc_i),
         .bd_i      (bd_i),
         .tnew_i    (tnew_i),
         .valid_o   (v_o[g]),
         .payload_o (p_o[g]),
         .pc8_o     (c_o[g]),
         .exc_o     (e_o[g]),
         .bd_o      (b_o[g]),
         .tnew_o    (t_o[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model_reset();
      for (int k = 0; k < 3; k++) begin
         m[k] = '{valid: 1'b0, payload: 64'd0, pc8: 32'h0000_3008, exc: 5'd0, bd: 1'b0, tnew: 3'd0};
      end
   endfunction

   // Apply one clock edge to the model following req > flush > stall > load.
   function automatic void model_step();
      for (int k = 0; k < 3; k++) begin
         if (req) begin
            m[k] = '{valid: 1'b0, payload: 64'd0, pc8: 32'h0000_4188, exc: 5'd0, bd: 1'b0, tnew: 3'd0};
         end else if (flush) begin
            m[k] = '{valid: 1'b0, payload: 64'd0, pc8: pc8_i, exc: 5'd0, bd: bd_i, tnew: 3'd0};
         end else if (stall) begin
            if (age_m[k] != 0 && m[k].tnew > 0) m[k].tnew = m[k].tnew - 3'd1;
         end else begin
            m[k] = '{valid: valid_i, payload: payload_i, pc8: pc8_i, exc: exc_i, bd: bd_i, tnew: tnew_i};
         end
      end
   endfunction

   function automatic st_t exp_out(int k);
      st_t e;
      int  t;
      e = m[k];
      if (dec_m[k] != 0) begin
         t = int'(m[k].tnew) - 1;
         if (t < 0) t = 0;
         e.tnew = 3'(t);
      end
      return e;
   endfunction

   function automatic st_t obs(int k);
      return {v_o[k], p_o[k], c_o[k], e_o[k], b_o[k], t_o[k]};
   endfunction

   task automatic tick();
      @(posedge clk);
      if (reset) model_step();
      #1;
   endtask

   task automatic drive(input logic rq, input logic fl, input logic st, input logic v,
                        input logic [63:0] p, input logic [31:0] pc, input logic [4:0] ex,
                        input logic b, input logic [2:0] t);
      req = rq; flush = fl; stall = st; valid_i = v;
      payload_i = p; pc8_i = pc; exc_i = ex; bd_i = b; tnew_i = t;
   endtask

   task automatic drive_rand_data();
      valid_i   = 1'($urandom);
      payload_i = {$urandom(), $urandom()};
      pc8_i     = $urandom();
      exc_i     = 5'($urandom);
      bd_i      = 1'($urandom);
      tnew_i    = 3'($urandom);
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 5'd0, 1'b0, 3'd0);
      model_reset();
      repeat (2) tick();
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 64'hDEAD_BEEF_0123_4567, 32'h0000_3100, 5'd12, 1'b1, 3'd5);
      tick();
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      for (int k = 0; k < 3; k++) begin
         tests++;
         if (obs(k) !== {1'b0, 64'd0, 32'h0000_3008, 5'd0, 1'b0, 3'd0}) begin
            fails++;
            $display("FAIL reset_async dut%0d got=%h exp=%h", k, obs(k),
                     {1'b0, 64'd0, 32'h0000_3008, 5'd0, 1'b0, 3'd0});
         end
      end
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h0000_0000_0000_00A5, 32'h0000_3010, 5'd0, 1'b0, 3'd0);
      tick();
      tests++;
      if (c_o[0] !== 32'h0000_3010 || p_o[0] !== 64'hA5 || v_o[0] !== 1'b1) begin
         fails++;
         $display("FAIL first_load got pc8=%h payload=%h valid=%b exp pc8=3010 payload=a5 valid=1",
                  c_o[0], p_o[0], v_o[0]);
      end
      for (int k = 0; k < 3; k++) begin
         tests++;
         if (obs(k) !== exp_out(k)) begin
            fails++;
            $display("FAIL first_load_model dut%0d got=%h exp=%h", k, obs(k), exp_out(k));
         end
      end
   endtask

   task automatic test_tnew_out();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h11, 32'h0000_3014, 5'd0, 1'b0, 3'd2);
      tick();
      tests++;
      if (t_o[0] !== 3'd1 || t_o[1] !== 3'd1 || t_o[2] !== 3'd2) begin
         fails++;
         $display("FAIL tnew_out_2 got=%0d,%0d,%0d exp=1,1,2", t_o[0], t_o[1], t_o[2]);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h12, 32'h0000_3018, 5'd0, 1'b0, 3'd0);
      tick();
      tests++;
      if (t_o[0] !== 3'd0 || t_o[1] !== 3'd0 || t_o[2] !== 3'd0) begin
         fails++;
         $display("FAIL tnew_out_0 got=%0d,%0d,%0d exp=0,0,0", t_o[0], t_o[1], t_o[2]);
      end
   endtask

   task automatic test_stall_age();
      logic [63:0] sp;
      logic [31:0] sc;
      int          exp_a [4] = '{1, 0, 0, 0};
      int          exp_c [4] = '{2, 1, 0, 0};
      sp = {$urandom(), $urandom()};
      sc = $urandom();
      drive(1'b0, 1'b0, 1'b0, 1'b1, sp, sc, 5'd0, 1'b0, 3'd3);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive_rand_data();
         stall = 1'b1;
         tick();
         tests++;
         if (t_o[0] !== 3'(exp_a[i]) || t_o[1] !== 3'd2 || t_o[2] !== 3'(exp_c[i]) ||
             p_o[0] !== sp || c_o[0] !== sc || p_o[1] !== sp || c_o[1] !== sc) begin
            fails++;
            $display("FAIL stall_age%0d got tnew=%0d,%0d,%0d pc8=%h exp tnew=%0d,2,%0d pc8=%h",
                     i, t_o[0], t_o[1], t_o[2], c_o[0], exp_a[i], exp_c[i], sc);
         end
      end
   endtask

   task automatic test_flush();
      drive(1'b0, 1'b1, 1'b1, 1'b1, 64'hFFFF_0000_1234_5678, 32'h0000_3024, 5'd10, 1'b1, 3'd4);
      tick();
      for (int k = 0; k < 3; k++) begin
         tests++;
         if (v_o[k] !== 1'b0 || p_o[k] !== 64'd0 || e_o[k] !== 5'd0 ||
             c_o[k] !== 32'h0000_3024 || b_o[k] !== 1'b1 || t_o[k] !== 3'd0) begin
            fails++;
            $display("FAIL flush dut%0d got=%h exp valid=0 payload=0 exc=0 pc8=3024 bd=1 tnew=0",
                     k, obs(k));
         end
      end
   endtask

   task automatic test_req();
      drive(1'b1, 1'b1, 1'b1, 1'b1, 64'h0BAD_F00D_CAFE_0001, 32'h0000_3030, 5'd4, 1'b1, 3'd6);
      tick();
      for (int k = 0; k < 3; k++) begin
         tests++;
         if (c_o[k] !== 32'h0000_4188 || b_o[k] !== 1'b0 || v_o[k] !== 1'b0 ||
             t_o[k] !== 3'd0 || p_o[k] !== 64'd0 || e_o[k] !== 5'd0) begin
            fails++;
            $display("FAIL req dut%0d got=%h exp pc8=4188 and all else 0", k, obs(k));
         end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 5'd0, 1'b0, 3'd0);
      drive_rand_data();
      tick();
      for (int k = 0; k < 3; k++) begin
         tests++;
         if (obs(k) !== exp_out(k)) begin
            fails++;
            $display("FAIL req_resume dut%0d got=%h exp=%h", k, obs(k), exp_out(k));
         end
      end
   endtask

   task automatic test_reset_mid_stall();
      drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h77, 32'h0000_3040, 5'd0, 1'b1, 3'd3);
      tick();
      stall = 1'b1;
      tick();
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      tests++;
      if (c_o[0] !== 32'h0000_3008 || c_o[1] !== 32'h0000_3008 || c_o[2] !== 32'h0000_3008 ||
          v_o !== 3'b000 || b_o !== 3'b000) begin
         fails++;
         $display("FAIL reset_mid_stall got pc8=%h,%h,%h exp 3008", c_o[0], c_o[1], c_o[2]);
      end
      reset = 1'b1;
      repeat (2) tick();
      for (int k = 0; k < 3; k++) begin
         tests++;
         if (obs(k) !== {1'b0, 64'd0, 32'h0000_3008, 5'd0, 1'b0, 3'd0} || obs(k) !== exp_out(k)) begin
            fails++;
            $display("FAIL stall_after_reset dut%0d got=%h exp=%h", k, obs(k), exp_out(k));
         end
      end
      stall = 1'b0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive_rand_data();
         req   = ($urandom_range(0, 15) == 0);
         flush = ($urandom_range(0, 7) == 0);
         stall = ($urandom_range(0, 3) == 0);
         tick();
         for (int k = 0; k < 3; k++) begin
            tests++;
            if (obs(k) !== exp_out(k)) begin
               fails++;
               $display("FAIL random%0d dut%0d got=%h exp=%h", i, k, obs(k), exp_out(k));
            end
         end
         if ($urandom_range(0, 63) == 0) begin
            #2;
            reset = 1'b0;
            #1;
            model_reset();
            tests++;
            if (obs(0) !== exp_out(0)) begin
               fails++;
               $display("FAIL random_reset%0d got=%h exp=%h", i, obs(0), exp_out(0));
            end
            reset = 1'b1;
         end
      end
   endtask

   initial begin
      test_reset();
      test_tnew_out();
      test_stall_age();
      test_flush();
      test_req();
      test_reset_mid_stall();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
